// File: rtl/rf_pkg.sv
// rtl/rf_pkg.sv - shared defaults and reset-pattern helper for the 2R1W register file
// Purpose: default widths, reset-pattern selectors and the init_val() helper
//          used to build each register's reset value.
// Ports:   none (package).
package rf_pkg;

  localparam int DEF_DATA_W    = 32;
  localparam int DEF_ADDR_W    = 5;
  localparam int INIT_IDENTITY = 1;
  localparam int INIT_ZERO     = 0;

  // Reset values are produced at a fixed wide width and sliced down by the
  // user, so DATA_W is limited to INIT_VAL_W bits.
  localparam int INIT_VAL_W = 64;

  function automatic logic [INIT_VAL_W-1:0] init_val(input int idx, input int mode);
    if (mode == INIT_IDENTITY) return INIT_VAL_W'(idx);
    return '0;
  endfunction

endpackage

// File: rtl/rf_read_port.sv
// rtl/rf_read_port.sv - one combinational read port with optional write bypass
// Purpose: selects the addressed register, reports whether it is free of a
//          pending producer, and optionally forwards a same-cycle write.
// Ports:   rd_addr_i          read address
//          regs_i / pend_i    register contents and pending bits
//          wr_ok_i, wr_addr_i, wr_data_i   qualified write this cycle
//          rsv_ok_i, rsv_addr_i            qualified reserve this cycle
//          rd_data_o, rd_rdy_o             read result and ready flag
module rf_read_port
  import rf_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int NUM_REGS = 32,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 1
) (
  input  logic [ADDR_W-1:0]   rd_addr_i,
  input  logic [DATA_W-1:0]   regs_i [NUM_REGS],
  input  logic [NUM_REGS-1:0] pend_i,
  input  logic                wr_ok_i,
  input  logic [ADDR_W-1:0]   wr_addr_i,
  input  logic [DATA_W-1:0]   wr_data_i,
  input  logic                rsv_ok_i,
  input  logic [ADDR_W-1:0]   rsv_addr_i,
  output logic [DATA_W-1:0]   rd_data_o,
  output logic                rd_rdy_o
);

  localparam int              IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [ADDR_W:0] NREGS = (ADDR_W+1)'(NUM_REGS);

  logic [IDX_W-1:0] rd_idx;
  assign rd_idx = rd_addr_i[IDX_W-1:0];

  always_comb begin
    rd_data_o = '0;
    rd_rdy_o  = 1'b1;
    // Unimplemented addresses and a hard-wired r0 read as a free zero.
    if (({1'b0, rd_addr_i} < NREGS) && !(ZERO_REG != 0 && rd_addr_i == '0)) begin
      rd_data_o = regs_i[rd_idx];
      rd_rdy_o  = !pend_i[rd_idx];
      // wr_ok_i is already qualified, so a bypass hit is always a real write;
      // a reserve in the same cycle means a newer producer is still in flight.
      if (BYPASS != 0 && wr_ok_i && wr_addr_i == rd_addr_i) begin
        rd_data_o = wr_data_i;
        rd_rdy_o  = !(rsv_ok_i && rsv_addr_i == rd_addr_i);
      end
    end
  end

endmodule

// File: rtl/regfile_2r1w.sv
// rtl/regfile_2r1w.sv - parametrised 2-read/1-write register file with pending bits
// Purpose: register array, per-register pending (scoreboard) bits, pending
//          count and write/reserve decode; two rf_read_port instances.
// Ports:   clk, rst                 clock, async active-high reset
//          rd_addr1/2 -> rd_data1/2, rd_rdy1/2   combinational reads
//          wr_en, wr_addr, wr_data  write port (also releases pending)
//          rsv_en, rsv_addr         reserve port (marks pending)
//          pend_cnt                 registered number of pending registers
module regfile_2r1w
  import rf_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int NUM_REGS  = 32,
  parameter int BYPASS    = 1,
  parameter int ZERO_REG  = 1,
  parameter int INIT_MODE = INIT_IDENTITY
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] rd_addr1,
  output logic [DATA_W-1:0] rd_data1,
  output logic              rd_rdy1,
  input  logic [ADDR_W-1:0] rd_addr2,
  output logic [DATA_W-1:0] rd_data2,
  output logic              rd_rdy2,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rsv_en,
  input  logic [ADDR_W-1:0] rsv_addr,
  output logic [ADDR_W:0]   pend_cnt
);

  localparam int              IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [ADDR_W:0] NREGS = (ADDR_W+1)'(NUM_REGS);

  logic [DATA_W-1:0]   regs_q [NUM_REGS];
  logic [NUM_REGS-1:0] pend_q, pend_d;
  logic [ADDR_W:0]     cnt_q, cnt_d;
  logic                wr_ok, rsv_ok, pend_set, pend_clr;
  logic [IDX_W-1:0]    wr_idx, rsv_idx;

  function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
    return ({1'b0, a} < NREGS) && !(ZERO_REG != 0 && a == '0);
  endfunction

  function automatic logic [DATA_W-1:0] init_word(input int i);
    logic [INIT_VAL_W-1:0] v;
    v = init_val(i, INIT_MODE);
    return v[DATA_W-1:0];
  endfunction

  // Gating with rst keeps the bypass path quiet during reset so reads show
  // the init pattern even if a write strobe is still asserted.
  assign wr_ok   = !rst && wr_en  && addr_ok(wr_addr);
  assign rsv_ok  = !rst && rsv_en && addr_ok(rsv_addr);
  assign wr_idx  = wr_addr[IDX_W-1:0];
  assign rsv_idx = rsv_addr[IDX_W-1:0];

  always_comb begin
    pend_d = pend_q;
    if (wr_ok)  pend_d[wr_idx]  = 1'b0;
    // Reserve applied last: a newer producer outranks the write that retires.
    if (rsv_ok) pend_d[rsv_idx] = 1'b1;
    pend_set = rsv_ok && !pend_q[rsv_idx];
    pend_clr = wr_ok && pend_q[wr_idx] && !(rsv_ok && rsv_idx == wr_idx);
    cnt_d    = cnt_q + (ADDR_W+1)'(pend_set) - (ADDR_W+1)'(pend_clr);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= init_word(i);
      pend_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (wr_ok) regs_q[wr_idx] <= wr_data;
      pend_q <= pend_d;
      cnt_q  <= cnt_d;
    end
  end

  assign pend_cnt = cnt_q;

  rf_read_port #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_REGS(NUM_REGS),
    .BYPASS(BYPASS), .ZERO_REG(ZERO_REG)
  ) u_rd1 (
    .rd_addr_i(rd_addr1), .regs_i(regs_q), .pend_i(pend_q),
    .wr_ok_i(wr_ok), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
    .rsv_ok_i(rsv_ok), .rsv_addr_i(rsv_addr),
    .rd_data_o(rd_data1), .rd_rdy_o(rd_rdy1)
  );

  rf_read_port #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_REGS(NUM_REGS),
    .BYPASS(BYPASS), .ZERO_REG(ZERO_REG)
  ) u_rd2 (
    .rd_addr_i(rd_addr2), .regs_i(regs_q), .pend_i(pend_q),
    .wr_ok_i(wr_ok), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
    .rsv_ok_i(rsv_ok), .rsv_addr_i(rsv_addr),
    .rd_data_o(rd_data2), .rd_rdy_o(rd_rdy2)
  );

endmodule
